// File: rtl/exp_ofuf_pipe.sv
// exp_ofuf_pipe: two-stage exponent add/unbias with overflow/underflow/zero flags, sticky flags and counter.
// Define EXP_SATURATE_EN to clamp exp_out on overflow (all ones) and underflow (zero).
module exp_ofuf_pipe #(
    parameter int EXP_WIDTH = 8,
    parameter int BIAS      = 2**(EXP_WIDTH-1)-1,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 valid_in,
    output logic                 ready_out,
    input  logic [EXP_WIDTH-1:0] a_exp_in,
    input  logic [EXP_WIDTH-1:0] b_exp_in,
    input  logic                 norm_inc_in,
    output logic                 valid_out,
    input  logic                 ready_in,
    output logic [EXP_WIDTH-1:0] exp_out,
    output logic                 overflow_out,
    output logic                 underflow_out,
    output logic                 zero_out,
    input  logic                 clear_flags_in,
    output logic                 ovf_sticky_out,
    output logic                 unf_sticky_out,
    output logic [CNT_WIDTH-1:0] exc_count_out
);
    localparam int SW = EXP_WIDTH + 2;
    localparam logic signed [SW-1:0] EXP_MAX = SW'((2**EXP_WIDTH) - 1);
    localparam logic signed [SW-1:0] EXP_MIN = '0;

    logic                 r_s1_valid, r_s1_zero, r_s2_valid;
    logic signed [SW-1:0] r_s1;
    logic [EXP_WIDTH-1:0] r_exp;
    logic                 r_ovf, r_unf, r_zero, r_ovs, r_uns;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 w_s2_adv, w_in_xfer, w_out_xfer, w_ovf, w_unf;
    logic signed [SW-1:0] w_sum;
    logic [EXP_WIDTH-1:0] w_exp;

    assign w_s2_adv   = !r_s2_valid || ready_in;
    assign ready_out  = !r_s1_valid || w_s2_adv;
    assign w_in_xfer  = valid_in && ready_out;
    assign w_out_xfer = r_s2_valid && ready_in;
    assign w_sum      = SW'(a_exp_in) + SW'(b_exp_in) + SW'(norm_inc_in) - SW'(BIAS);
    assign w_ovf      = !r_s1_zero && (r_s1 >= EXP_MAX);
    assign w_unf      = !r_s1_zero && (r_s1 <= EXP_MIN);
`ifdef EXP_SATURATE_EN
    assign w_exp = r_s1_zero ? '0 : w_ovf ? '1 : w_unf ? '0 : r_s1[EXP_WIDTH-1:0];
`else
    assign w_exp = r_s1_zero ? '0 : r_s1[EXP_WIDTH-1:0];
`endif

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_s1_valid <= 1'b0;
            r_s1_zero  <= 1'b0;
            r_s1       <= '0;
            r_s2_valid <= 1'b0;
            r_exp      <= '0;
            r_ovf      <= 1'b0;
            r_unf      <= 1'b0;
            r_zero     <= 1'b0;
        end else begin
            if (ready_out) r_s1_valid <= valid_in;
            if (w_in_xfer) begin
                r_s1      <= w_sum;
                r_s1_zero <= (a_exp_in == '0) || (b_exp_in == '0);
            end
            if (w_s2_adv) r_s2_valid <= r_s1_valid;
            if (w_s2_adv && r_s1_valid) begin
                r_exp  <= w_exp;
                r_ovf  <= w_ovf;
                r_unf  <= w_unf;
                r_zero <= r_s1_zero;
            end
        end
    end

    // Flag events are taken from the result actually handed downstream; clear beats a same-cycle event.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_ovs <= 1'b0;
            r_uns <= 1'b0;
            r_cnt <= '0;
        end else if (clear_flags_in) begin
            r_ovs <= 1'b0;
            r_uns <= 1'b0;
            r_cnt <= '0;
        end else if (w_out_xfer) begin
            r_ovs <= r_ovs || r_ovf;
            r_uns <= r_uns || r_unf;
            if ((r_ovf || r_unf) && !(&r_cnt)) r_cnt <= r_cnt + CNT_WIDTH'(1);
        end
    end

    assign valid_out      = r_s2_valid;
    assign exp_out        = r_exp;
    assign overflow_out   = r_ovf;
    assign underflow_out  = r_unf;
    assign zero_out       = r_zero;
    assign ovf_sticky_out = r_ovs;
    assign unf_sticky_out = r_uns;
    assign exc_count_out  = r_cnt;
endmodule
